// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
//
// Receive end of the XOR-based serial parity link. It deserializes an
// LSB-first stream of DATA_W data bits followed by one parity bit. Received
// data bits are XOR-accumulated, and the result is checked against the parity
// bit. Each completed word is offered on a valid/ready output together with
// its parity-error flag. A saturating count of bad frames is also kept.
//
// Build option:
//   SERIAL_PARITY_RX_ODD_EN  defined   -> odd parity. A frame is good when the
//                                         data bits plus the parity bit hold an
//                                         odd number of ones.
//                            undefined -> even parity (default).
//   Both builds have the same ports and the same timing.
//
// Parameters:
//   DATA_W  data bits per frame, parity excluded (2..32)
//   CNT_W   width of the saturating parity-error counter
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sin_valid   sin_bit / sin_sof are valid this cycle
//   sin_bit     serial data or parity bit
//   sin_sof     marks the first data bit (bit 0) of a frame
//   sin_ready   receiver accepts a serial bit this cycle (low only in HOLD)
//   dout        received word; bit 0 is the first bit received
//   dout_valid  dout / par_err valid
//   dout_ready  consumer accepts the word
//   par_err     parity mismatch for the word on dout
//   err_cnt     saturating count of frames that had par_err = 1
// -----------------------------------------------------------------------------
module serial_parity_rx #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin_valid,
  input  logic              sin_bit,
  input  logic              sin_sof,
  output logic              sin_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              par_err,
  output logic [CNT_W-1:0]  err_cnt
);

  // The bit counter must be able to hold DATA_W itself.
  localparam int CW = $clog2(DATA_W + 1);

`ifdef SERIAL_PARITY_RX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_acc;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_par_err;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_accept;
  logic              w_start;
  logic              w_data;
  logic              w_par;
  logic              w_release;
  logic              w_last;
  logic              w_perr;

  // Increments the counter and holds it at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign sin_ready  = (r_state != S_HOLD);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign par_err    = r_par_err;
  assign err_cnt    = r_err_cnt;

  assign w_accept = sin_valid && sin_ready;
  // The data bit being accepted now is the final one of the word.
  assign w_last   = (r_cnt == CW'(DATA_W - 1));
  assign w_perr   = r_acc ^ sin_bit ^ ODD;

  // Next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_data      = 1'b0;
    w_par       = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && sin_sof) begin
          w_start     = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          if (sin_sof) begin
            // Abandon the partial frame; this bit becomes bit 0 of a new one.
            w_start     = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_data      = 1'b1;
            w_state_nxt = w_last ? S_PAR : S_DATA;
          end
        end
      end
      S_PAR: begin
        if (w_accept) begin
          if (sin_sof) begin
            w_start     = 1'b1;
            w_state_nxt = S_DATA;
          end else begin
            w_par       = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (r_dout_valid && dout_ready) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Deserializer: each new bit enters at the MSB and moves down. After DATA_W
  // shifts, the first bit received sits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
    end else if (w_start) begin
      r_shift <= {sin_bit, r_shift[DATA_W-1:1]};
      r_cnt   <= CW'(1);
      r_acc   <= sin_bit;
    end else if (w_data) begin
      r_shift <= {sin_bit, r_shift[DATA_W-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= r_acc ^ sin_bit;
    end
  end

  // Output word, error flag and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_err_cnt    <= '0;
    end else if (w_par) begin
      r_dout       <= r_shift;
      r_par_err    <= w_perr;
      r_dout_valid <= 1'b1;
      if (w_perr) begin
        r_err_cnt <= sat_inc(r_err_cnt);
      end
    end else if (w_release) begin
      // dout and par_err keep their last value; only valid drops.
      r_dout_valid <= 1'b0;
    end
  end

endmodule
